// File: rtl/xheep_jtag_shift_master.sv
// xheep_jtag_shift_master: hardware JTAG initiator that shifts TMS/TDI bit strings into the
// x_heep_system debug TAP with hardware-timed TCK and returns the captured TDO bits.
//   clk_gen, rst_n (async, active-low)  system clock and reset
//   cmd_*_i / cmd_ready_o              command: length (saturates at 32), TMS, TDI, TRST request
//   rsp_valid_o / rsp_ready_i / rsp_tdo_o  response carrying captured TDO (LSB = first bit)
//   busy_o                             high from command accept until response handshake
//   jtag_*                             JTAG pins towards/from the TAP
// Optional feature: define JTAG_MASTER_TRST_EN to make cmd_trst_i issue a TRST pulse.
module xheep_jtag_shift_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_tms_i,
  input  logic [31:0] cmd_tdi_i,
  input  logic        cmd_trst_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        busy_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  output logic        jtag_trst_no,
  input  logic        jtag_tdo_i
);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, TRST, RESP} state_e;
  localparam logic [7:0] DivM1 = 8'(CLK_DIV - 1);
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  idx_q;
  logic [5:0]  len_q;
  logic [31:0] tms_q, tdi_q, tdo_q;
  logic        ready_q, valid_q, busy_q, tck_q, tmso_q, tdio_q;
  logic        cnt_done, last_bit;
  logic [4:0]  idx_nx;
  logic [5:0]  len_sat;
  assign cnt_done = cnt_q == DivM1;
  assign last_bit = {1'b0, idx_q} == len_q - 6'd1;
  assign idx_nx   = idx_q + 5'd1;
  assign len_sat  = cmd_len_i > 6'd32 ? 6'd32 : cmd_len_i;
`ifdef JTAG_MASTER_TRST_EN
  // The TRST pulse lasts two CLK_DIV periods; half_q marks the second one so the
  // 8-bit counter never has to reach 2*CLK_DIV.
  logic trst_q, half_q;
  assign jtag_trst_no = trst_q;
`else
  logic unused_trst;
  assign unused_trst  = cmd_trst_i;
  assign jtag_trst_no = 1'b1;
`endif
  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_tdo_o   = tdo_q;
  assign busy_o      = busy_q;
  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tmso_q;
  assign jtag_tdi_o  = tdio_q;
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      tdo_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tck_q   <= 1'b0;
      tmso_q  <= 1'b1;
      tdio_q  <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
      trst_q  <= 1'b1;
      half_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          len_q   <= len_sat;
          tms_q   <= cmd_tms_i;
          tdi_q   <= cmd_tdi_i;
          tdo_q   <= '0;
          idx_q   <= '0;
          cnt_q   <= '0;
`ifdef JTAG_MASTER_TRST_EN
          half_q  <= 1'b0;
          if (cmd_trst_i) begin
            state_q <= TRST;
            trst_q  <= 1'b0;
            tmso_q  <= 1'b1;
          end else
`endif
          if (len_sat == 6'd0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end else begin
            state_q <= LOW;
            tmso_q  <= cmd_tms_i[0];
            tdio_q  <= cmd_tdi_i[0];
          end
        end
        // TDO is sampled on the same clock that raises TCK: the target changed it on the
        // previous falling edge, so it has been stable for a full half-period.
        LOW: if (cnt_done) begin
          state_q      <= HIGH;
          cnt_q        <= '0;
          tck_q        <= 1'b1;
          tdo_q[idx_q] <= jtag_tdo_i;
        end else cnt_q <= cnt_q + 8'd1;
        HIGH: if (cnt_done) begin
          cnt_q <= '0;
          tck_q <= 1'b0;
          if (last_bit) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end else begin
            state_q <= LOW;
            idx_q   <= idx_nx;
            tmso_q  <= tms_q[idx_nx];
            tdio_q  <= tdi_q[idx_nx];
          end
        end else cnt_q <= cnt_q + 8'd1;
`ifdef JTAG_MASTER_TRST_EN
        TRST: if (cnt_done) begin
          cnt_q  <= '0;
          half_q <= 1'b1;
          if (half_q) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            trst_q  <= 1'b1;
          end
        end else cnt_q <= cnt_q + 8'd1;
`endif
        RESP: if (rsp_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
